addsub_nibble_seq: RTL and testbench

- Multi-cycle N-bit adder/subtractor controller.
- Sequences one shared 4-bit add/sub nibble datapath, LSB nibble first, and propagates carry/borrow between nibbles in a registered chain.
- Provides valid/ready request and response channels so a wide add/sub can be issued from a control FSM without a full-width adder.
- Select polarity matches the existing 4-bit block: sel_add1_sub0 = 1 is add, 0 is subtract.

---
 rtl/addsub_nibble_seq.sv | 123 ++++++++++++
 tb/tb_addsub_nibble_seq.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/addsub_nibble_seq.sv
`default_nettype none
// ============================================================================
// Module   : addsub_nibble_seq
// Brief    : W-bit add/sub through one shared 4-bit slice, LSB nibble first.
// Revision : 1.0
// ============================================================================
module addsub_nibble_seq #(
   parameter int NIBBLES = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic [4*NIBBLES-1:0] req_a,
   input  logic [4*NIBBLES-1:0] req_b,
   input  logic                 req_sel_add1_sub0,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic [4*NIBBLES-1:0] rsp_result,
   output logic                 rsp_carry_borrow_out,
   output logic                 rsp_overflow,
   output logic                 busy
);

   localparam int W  = 4 * NIBBLES;
   localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
   localparam logic [IW-1:0] c_LAST = IW'(NIBBLES - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t          r_state;
   logic [IW-1:0]   r_idx;
   logic            r_carry;
   logic            r_sel;
   logic [W-1:0]    r_a;
   logic [W-1:0]    r_b;
   logic [W-1:0]    r_result;
   logic            r_req_ready;
   logic            r_rsp_valid;
   logic            r_cbo;
   logic            r_ovf;
   logic            r_busy;

   logic [3:0]      w_a_nib;
   logic [3:0]      w_b_nib;
   logic [4:0]      w_sum;

   // Subtract is A + ~B + 1: the +1 comes from the carry seeded at accept.
   assign w_a_nib = r_a[{r_idx, 2'b00} +: 4];
   assign w_b_nib = r_sel ? r_b[{r_idx, 2'b00} +: 4] : ~r_b[{r_idx, 2'b00} +: 4];
   assign w_sum   = {1'b0, w_a_nib} + {1'b0, w_b_nib} + {4'b0000, r_carry};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_idx       <= '0;
         r_carry     <= 1'b0;
         r_sel       <= 1'b0;
         r_a         <= '0;
         r_b         <= '0;
         r_result    <= '0;
         r_req_ready <= 1'b0;
         r_rsp_valid <= 1'b0;
         r_cbo       <= 1'b0;
         r_ovf       <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_req_ready <= 1'b1;
               if (req_valid && r_req_ready) begin
                  r_a         <= req_a;
                  r_b         <= req_b;
                  r_sel       <= req_sel_add1_sub0;
                  r_carry     <= ~req_sel_add1_sub0;
                  r_idx       <= '0;
                  r_req_ready <= 1'b0;
                  r_busy      <= 1'b1;
                  r_state     <= S_RUN;
               end
            end
            S_RUN: begin
               r_result[{r_idx, 2'b00} +: 4] <= w_sum[3:0];
               r_carry <= w_sum[4];
               if (r_idx == c_LAST) begin
                  r_idx       <= '0;
                  r_cbo       <= r_sel ? w_sum[4] : ~w_sum[4];
                  // Same-sign operands giving an opposite-sign result <=> c_in(MSB) ^ c_out(MSB).
                  r_ovf       <= (w_a_nib[3] == w_b_nib[3]) && (w_sum[3] != w_a_nib[3]);
                  r_rsp_valid <= 1'b1;
                  r_state     <= S_DONE;
               end else begin
                  r_idx <= r_idx + 1'b1;
               end
            end
            S_DONE: begin
               if (rsp_ready) begin
                  r_rsp_valid <= 1'b0;
                  r_busy      <= 1'b0;
                  r_req_ready <= 1'b1;
                  r_state     <= S_IDLE;
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign req_ready            = r_req_ready;
   assign rsp_valid            = r_rsp_valid;
   assign rsp_result           = r_result;
   assign rsp_carry_borrow_out = r_cbo;
   assign rsp_overflow         = r_ovf;
   assign busy                 = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_addsub_nibble_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_addsub_nibble_seq
// Brief    : Scoreboard bench for addsub_nibble_seq (NIBBLES = 4).
// Revision : 1.0
// ============================================================================
module tb_addsub_nibble_seq;

   localparam int NIBBLES = 4;
   localparam int W       = 4 * NIBBLES;

   typedef struct {
      logic [W-1:0] res;
      logic         cb;
      logic         ov;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          req_valid = 1'b0;
   logic          req_ready;
   logic [W-1:0]  req_a = '0;
   logic [W-1:0]  req_b = '0;
   logic          req_sel = 1'b0;
   logic          rsp_valid;
   logic          rsp_ready = 1'b0;
   logic [W-1:0]  rsp_result;
   logic          rsp_cb;
   logic          rsp_ov;
   logic          busy;

   exp_t          sb_q[$];
   int            n_checks = 0;
   int            n_errors = 0;
   int            cyc = 0;

   addsub_nibble_seq #(.NIBBLES(NIBBLES)) u_dut (
      .clk                  (clk),
      .rst_n                (rst_n),
      .req_valid            (req_valid),
      .req_ready            (req_ready),
      .req_a                (req_a),
      .req_b                (req_b),
      .req_sel_add1_sub0    (req_sel),
      .rsp_valid            (rsp_valid),
      .rsp_ready            (rsp_ready),
      .rsp_result           (rsp_result),
      .rsp_carry_borrow_out (rsp_cb),
      .rsp_overflow         (rsp_ov),
      .busy                 (busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sel);
      exp_t e;
      logic [W:0] full;
      if (sel) begin
         full  = {1'b0, a} + {1'b0, b};
         e.res = full[W-1:0];
         e.cb  = full[W];
         e.ov  = (a[W-1] == b[W-1]) && (e.res[W-1] != a[W-1]);
      end else begin
         e.res = a - b;
         e.cb  = (a < b);
         e.ov  = (a[W-1] != b[W-1]) && (e.res[W-1] != a[W-1]);
      end
      return e;
   endfunction

   // Scoreboard consumer: compare whenever a response handshake is about to occur.
   always @(negedge clk) begin
      if (rst_n && rsp_valid && rsp_ready) begin
         if (sb_q.size() == 0) begin
            chk("unexpected_rsp", 64'(rsp_valid), 64'd0);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            chk("result", 64'(rsp_result), 64'(e.res));
            chk("carry_borrow", 64'(rsp_cb), 64'(e.cb));
            chk("overflow", 64'(rsp_ov), 64'(e.ov));
         end
      end
   end

   // Present a request and return #1 after the accepting edge; req_valid stays high.
   task automatic do_req(input logic [W-1:0] a, input logic [W-1:0] b, input logic sel,
                         input bit push, output int acc_cyc);
      int n;
      req_a = a; req_b = b; req_sel = sel; req_valid = 1'b1;
      n = 0;
      forever begin
         @(negedge clk);
         if (req_ready) break;
         n++;
         if (n > 50) begin
            chk("accept_timeout", 64'd1, 64'd0);
            break;
         end
      end
      if (push) sb_q.push_back(model(a, b, sel));
      @(posedge clk);
      #1;
      acc_cyc = cyc;
   endtask

   task automatic wait_rsp(output int lat);
      lat = 0;
      forever begin
         @(posedge clk);
         #1;
         lat++;
         if (rsp_valid) break;
         if (lat > 50) begin
            chk("rsp_timeout", 64'd1, 64'd0);
            break;
         end
      end
   endtask

   task automatic single_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sel);
      int acc, lat;
      do_req(a, b, sel, 1'b1, acc);
      req_valid = 1'b0;
      wait_rsp(lat);
      chk("latency", 64'(lat), 64'(NIBBLES));
      @(posedge clk);
      #1;
   endtask

   initial begin
      int acc, lat, prev;
      exp_t e;

      #12;
      chk("rst_req_ready", 64'(req_ready), 64'd0);
      chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("rst_result", 64'(rsp_result), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      rsp_ready = 1'b1;
      single_op(16'h1234, 16'h0FFF, 1'b1);
      single_op(16'hFFFF, 16'h0001, 1'b1);
      single_op(16'h7FFF, 16'h0001, 1'b1);
      single_op(16'h0004, 16'h0004, 1'b0);
      single_op(16'h0003, 16'h0007, 1'b0);
      single_op(16'h8000, 16'h0001, 1'b0);

      // Backpressure with req_a scribbled during RUN.
      rsp_ready = 1'b0;
      do_req(16'h5A5A, 16'h1357, 1'b0, 1'b1, acc);
      req_valid = 1'b0;
      req_a = 16'hDEAD;
      chk("busy_run", 64'(busy), 64'd1);
      wait_rsp(lat);
      chk("bp_latency", 64'(lat), 64'(NIBBLES));
      e = model(16'h5A5A, 16'h1357, 1'b0);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp_result", 64'(rsp_result), 64'(e.res));
         chk("bp_valid", 64'(rsp_valid), 64'd1);
         chk("bp_req_ready", 64'(req_ready), 64'd0);
      end
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("bp_done_valid", 64'(rsp_valid), 64'd0);

      // Abort mid-RUN: no response must follow.
      do_req(16'h1234, 16'h1111, 1'b1, 1'b0, acc);
      req_valid = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("abort_result", 64'(rsp_result), 64'd0);
      chk("abort_busy", 64'(busy), 64'd0);
      chk("abort_valid", 64'(rsp_valid), 64'd0);
      chk("abort_req_ready", 64'(req_ready), 64'd0);
      chk("abort_cb_ov", 64'({rsp_cb, rsp_ov}), 64'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      single_op(16'h000A, 16'h0004, 1'b1);

      // Back-to-back, req_valid and rsp_ready held high.
      do_req(16'h0F0F, 16'h00F1, 1'b1, 1'b1, prev);
      for (int i = 0; i < 4; i++) begin
         logic [W-1:0] a, b;
         logic s;
         a = W'($urandom);
         b = W'($urandom);
         s = 1'($urandom);
         do_req(a, b, s, 1'b1, acc);
         chk("b2b_interval", 64'(acc - prev), 64'(NIBBLES + 2));
         prev = acc;
      end
      req_valid = 1'b0;

      for (int i = 0; i < 50 && sb_q.size() != 0; i++) @(posedge clk);
      @(posedge clk);
      chk("sb_empty", 64'(sb_q.size()), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end

endmodule
`default_nettype wire
